axi4_burst_master: RTL

Single-outstanding AXI4 initiator that turns a simple command/stream interface into INCR bursts toward an AXI4 memory-mapped slave such as the project's memory slave.
It accepts one read or write command at a time, drives AW/W/B or AR/R, and reports completion with the final response.
It is the stimulus-side counterpart used by subsystems and by the integration bench.
Commands that are illegal under AXI4 are rejected locally and never reach the bus.

---
 rtl/axi4_burst_master_if.sv | 55 +++++
 rtl/axi4_burst_master.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master_if.sv
// AXI4 channel bundle between the burst master and a memory-mapped slave.
// Holds the AW, W, B, AR and R channels; clock and reset stay outside.
interface axi4_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WVALID;
    logic                  WLAST;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RLAST;
    logic                  RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWVALID,
        input  AWREADY,
        output WDATA, WVALID, WLAST,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID, RLAST,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWVALID,
        output AWREADY,
        input  WDATA, WVALID, WLAST,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID, RLAST,
        input  RREADY
    );
endinterface

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator driven by a command/stream port.
// Illegal commands (oversize beat, 4 KB crossing) are rejected without touching the bus.
module axi4_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    output logic                  cmd_err,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [1:0]            rd_resp,
    input  logic                  rd_ready,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  proto_err,
    axi4_burst_master_if.master   axi
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;

    localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WIDTH / 8));

    logic [2:0]            state;
    logic [7:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            resp_q;
    logic                  done_q;
    logic [1:0]            done_resp_q;
    logic                  cmd_err_q;
    logic                  proto_err_q;

    logic [20:0] beats;
    logic [20:0] end_b;
    logic        cmd_bad;
    logic        in_w;
    logic        in_r;
    logic        last_beat;
    logic        w_hs;
    logic        r_hs;

    // Burst end offset within the 4 KB page, kept wide so nothing truncates
    always_comb begin
        beats   = {13'd0, cmd_len} + 21'd1;
        end_b   = {9'd0, cmd_addr[11:0]} + (beats << cmd_size);
        cmd_bad = (cmd_size > SIZE_MAX) || (end_b > 21'd4096);
    end

    assign in_w      = (state == S_W);
    assign in_r      = (state == S_R);
    assign last_beat = (cnt == len_q);
    assign w_hs      = in_w && wr_valid && axi.WREADY;
    assign r_hs      = in_r && axi.RVALID && rd_ready;

    assign cmd_ready = (state == S_IDLE);
    assign cmd_err   = cmd_err_q;
    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign proto_err = proto_err_q;

    assign axi.AWVALID = (state == S_AW);
    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = len_q;
    assign axi.AWSIZE  = size_q;
    assign axi.ARVALID = (state == S_AR);
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = len_q;
    assign axi.ARSIZE  = size_q;

    assign axi.WVALID = in_w && wr_valid;
    assign axi.WDATA  = in_w ? wr_data : '0;
    assign axi.WLAST  = in_w && last_beat;
    assign wr_ready   = in_w && axi.WREADY;
    assign axi.BREADY = (state == S_B);

    assign axi.RREADY = in_r && rd_ready;
    assign rd_valid   = in_r && axi.RVALID;
    assign rd_data    = in_r ? axi.RDATA : '0;
    assign rd_resp    = in_r ? axi.RRESP : 2'b00;
    assign rd_last    = in_r && axi.RLAST;

    // Command capture, burst sequencing and completion reporting
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            resp_q      <= '0;
            done_q      <= 1'b0;
            done_resp_q <= '0;
            cmd_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        size_q <= cmd_size;
                        cnt    <= '0;
                        resp_q <= '0;
                        if (cmd_bad) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            state <= cmd_write ? S_AW : S_AR;
                        end
                    end
                end
                S_AW: begin
                    if (axi.AWREADY) state <= S_W;
                end
                S_W: begin
                    if (w_hs) begin
                        cnt <= cnt + 8'd1;
                        if (last_beat) state <= S_B;
                    end
                end
                S_B: begin
                    if (axi.BVALID) begin
                        done_q      <= 1'b1;
                        done_resp_q <= axi.BRESP;
                        state       <= S_IDLE;
                    end
                end
                S_AR: begin
                    if (axi.ARREADY) state <= S_R;
                end
                S_R: begin
                    if (r_hs) begin
                        cnt <= cnt + 8'd1;
                        if (resp_q == 2'b00 && axi.RRESP != 2'b00) begin
                            resp_q <= axi.RRESP;
                        end
                        if (last_beat != axi.RLAST) proto_err_q <= 1'b1;
                        if (last_beat) begin
                            done_q      <= 1'b1;
                            done_resp_q <= (resp_q != 2'b00) ? resp_q : axi.RRESP;
                            state       <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
